// File: rtl/mem_responder.sv
// Line-granular memory responder: accepts one fill/writeback request, waits a fixed
// latency, then steps the line word by word against an internal word array.
`ifndef CACHE_B
`define CACHE_B 4
`endif

module mem_responder #(
  parameter int OFFSET_WIDTH = `CACHE_B,
  parameter int MEM_DEPTH    = 1024,
  parameter int LATENCY      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic        ready_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] read_data_o,
  output logic        data_valid_o,
  output logic        done_o
);

  localparam int WORDS = 1 << (OFFSET_WIDTH - 2);
  localparam int BW    = OFFSET_WIDTH - 2;
  localparam int AW    = $clog2(MEM_DEPTH);
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

  typedef struct packed {
    logic [31-OFFSET_WIDTH:0] line;
    logic                     we;
  } req_t;

  state_t          state, state_nxt;
  req_t            req_q;
  logic [CW-1:0]   wait_cnt;
  logic [BW-1:0]   beat;
  logic [31:0]     mem [MEM_DEPTH];
  logic [AW-1:0]   idx;
  logic            xfer;
  logic            unused_addr;

  assign unused_addr = ^addr_i[OFFSET_WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_i) state_nxt = WAIT;
      WAIT: if (wait_cnt == '0) state_nxt = XFER;
      XFER: if (beat == BW'(WORDS - 1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      req_q    <= '0;
      wait_cnt <= '0;
      beat     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_i) begin
          req_q.line <= addr_i[31:OFFSET_WIDTH];
          req_q.we   <= we_i;
          wait_cnt   <= CW'(LATENCY - 1);
        end
        WAIT: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
          beat <= '0;
        end
        XFER: beat <= beat + 1'b1;
        default: ;
      endcase
    end
  end

  assign xfer         = (state == XFER);
  assign ready_o      = (state == IDLE);
  assign done_o       = (state == DONE);
  assign data_valid_o = xfer && !req_q.we;
  // Beat is concatenated below the line base, so the burst can never leave the line.
  assign mem_addr_o   = xfer ? {req_q.line, beat, 2'b00} : {req_q.line, OFFSET_WIDTH'(0)};
  assign idx          = mem_addr_o[AW+1:2];
  assign read_data_o  = data_valid_o ? mem[idx] : '0;

  // Store is never cleared; a reset edge suppresses the beat in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i && xfer && req_q.we) mem[idx] <= write_data_i;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, corner sequences and
// random bursts checked against a flat word-array model of main memory.
module tb_mem_responder;
  localparam int OW = 4, LAT = 2, DEPTH = 1024, WORDS = 4;

  logic        clk = 0, rst = 0, req = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic        ready, dv, done;
  logic [31:0] maddr, rdata;

  mem_responder #(.OFFSET_WIDTH(OW), .MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .write_data_i(wdata), .ready_o(ready), .mem_addr_o(maddr),
    .read_data_o(rdata), .data_valid_o(dv), .done_o(done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] model [DEPTH];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dbase;
    logic        chk_first;
    logic [31:0] exp_first;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int midx(logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic idle_chk(string tag, logic [31:0] base);
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_dv"}, 32'(dv), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_maddr"}, maddr, base);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after DONE.
  task automatic burst(input logic w, input logic [31:0] a, input logic rnd,
                       input logic [31:0] dbase, input logic poke, output logic [31:0] first);
    logic [31:0] base, ba, d;
    base  = {a[31:OW], 4'b0};
    first = '0;
    chk("ready_pre", 32'(ready), 1);
    req = 1; we = w; addr = a;
    @(negedge clk);
    req = 0; we = 1'($urandom); addr = $urandom;
    for (int i = 0; i < LAT; i++) begin
      chk("wait_ready", 32'(ready), 0);
      chk("wait_dv", 32'(dv), 0);
      chk("wait_done", 32'(done), 0);
      chk("wait_maddr", maddr, base);
      if (poke && i == 0) begin req = 1; we = 1; addr = 32'h300; end
      @(negedge clk);
      req = 0;
    end
    for (int k = 0; k < WORDS; k++) begin
      ba = base + 32'(4 * k);
      chk("xfer_maddr", maddr, ba);
      chk("xfer_ready", 32'(ready), 0);
      chk("xfer_done", 32'(done), 0);
      if (!w) begin
        chk("fill_dv", 32'(dv), 1);
        chk("fill_data", rdata, model[midx(ba)]);
        if (k == 0) first = rdata;
      end else begin
        chk("wb_dv", 32'(dv), 0);
        d = rnd ? $urandom : dbase + 32'(k);
        wdata = d;
        model[midx(ba)] = d;
      end
      @(negedge clk);
    end
    chk("done_pulse", 32'(done), 1);
    chk("done_ready", 32'(ready), 0);
    chk("done_dv", 32'(dv), 0);
    chk("done_maddr", maddr, base);
    @(negedge clk);
    idle_chk("post", base);
  endtask

  initial begin
    logic [31:0] f;
    tbl[0] = '{1'b0, 32'h0000_0048, 32'h0,         1'b1, 32'hA000_0010};
    tbl[1] = '{1'b1, 32'h0000_0080, 32'hDEAD_0000, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 32'h0000_0080, 32'h0,         1'b1, 32'hDEAD_0000};
    tbl[3] = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'hA000_0000};
    tbl[4] = '{1'b1, 32'hFFFF_FFFC, 32'h5555_0000, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 32'h0000_3FF0, 32'h0,         1'b1, 32'h5555_0000};

    repeat (2) @(negedge clk);
    idle_chk("reset", 32'h0);
    rst = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      idle_chk("idle", 32'h0);
    end

    // Preload word i = 0xA000_0000 + i through writeback bursts.
    for (int l = 0; l < DEPTH / WORDS; l++)
      burst(1'b1, 32'(l * 16), 1'b0, 32'hA000_0000 + 32'(l * 4), 1'b0, f);

    for (int v = 0; v < 6; v++) begin
      burst(tbl[v].we, tbl[v].addr, 1'b0, tbl[v].dbase, 1'b0, f);
      if (tbl[v].chk_first) chk($sformatf("tbl%0d_first", v), f, tbl[v].exp_first);
    end

    // Reset during write beat 2 of line 0x100.
    req = 1; we = 1; addr = 32'h100;
    @(negedge clk);
    req = 0;
    repeat (LAT) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      wdata = 32'hBEEF_0000 + 32'(k);
      model[midx(32'h100 + 32'(4 * k))] = wdata;
      @(negedge clk);
    end
    wdata = 32'hBEEF_0002;
    rst = 0;
    @(negedge clk);
    idle_chk("midrst", 32'h0);
    rst = 1;
    burst(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, f);
    chk("midrst_beat0", f, 32'hBEEF_0000);

    // Request pulsed during WAIT must not start a second burst.
    burst(1'b0, 32'h200, 1'b0, 32'h0, 1'b1, f);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle_chk("noburst", 32'h200);
    end
    burst(1'b0, 32'h300, 1'b0, 32'h0, 1'b0, f);
    chk("noburst_data", f, 32'hA000_00C0);

    for (int r = 0; r < 40; r++)
      burst(1'($urandom), $urandom & 32'h0000_FFFF, 1'b1, 32'h0, 1'b0, f);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the cache's line fill and writeback traffic. It accepts one line-granular request at a time from the cache controller, waits a configurable access latency, then streams the line word by word. Each burst word is presented as a word address plus read data, in the form the cache set consumes on its memory address and memory read data inputs. For writebacks it steps the same word addresses and captures the cache's write data. Backing store is an internal word array, used as the main-memory model for the cache testbench.

## Interface
- OFFSET_WIDTH, default `CACHE_B: line offset bits; WORDS = 2^(OFFSET_WIDTH-2) words per burst (OFFSET_WIDTH ≥ 3).
- MEM_DEPTH, default 1024: backing store size in 32-bit words, power of two.
- LATENCY, default 4: wait cycles between request acceptance and first burst word, ≥ 1.
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- req_i  input  1  request strobe; sampled only while ready_o = 1.
- we_i  input  1  1 = writeback burst, 0 = fill burst; sampled with req_i.
- addr_i  input  32  request address; bits [OFFSET_WIDTH-1:0] ignored (line-aligned internally).
- write_data_i  input  32  writeback word for the current mem_addr_o; sampled each XFER cycle of a write burst.
- ready_o  output  1  idle, can accept req_i.
- mem_addr_o  output  32  word address of the current burst beat: line base + 4·beat.
- read_data_o  output  32  store contents at mem_addr_o; meaningful when data_valid_o = 1.
- data_valid_o  output  1  fill beat valid this cycle.
- done_o  output  1  one-cycle pulse: burst complete.

## Operation
- States: IDLE, WAIT, XFER, DONE.
- IDLE: ready_o = 1. If req_i = 1, latch base = {addr_i[31:OFFSET_WIDTH], 0}, latch we_i, load wait counter = LATENCY-1, go to WAIT. Otherwise stay.
- WAIT: decrement counter. At 0, clear beat counter and go to XFER.
- XFER: mem_addr_o = base + {beat, 2'b00}.
  - Fill: data_valid_o = 1 and read_data_o = mem[index], read asynchronously from the array.
  - Writeback: data_valid_o = 0; on the clock edge, mem[index] <= write_data_i.
  - Beat increments every cycle. After beat WORDS-1, go to DONE.
- DONE: done_o = 1 for one cycle, then IDLE.
- index = mem_addr_o[$clog2(MEM_DEPTH)+1:2]. Addresses beyond MEM_DEPTH alias modulo MEM_DEPTH, with no error.
- The beat counter is OFFSET_WIDTH-2 bits wide. The burst never crosses a line boundary: the address stays within base..base+4·(WORDS-1).
- Outside XFER: mem_addr_o holds base (0 after reset), read_data_o = 0, data_valid_o = 0.
- req_i asserted outside IDLE is ignored, not queued. The requester must hold or reissue req_i after ready_o returns.
- Reset (rst_i = 0 at an edge), including mid-burst: state → IDLE, counters and base → 0, outputs at reset values. Any partially written line keeps the beats already written. The array is never cleared by reset.
- Reset values: ready_o = 1, mem_addr_o = 0, read_data_o = 0, data_valid_o = 0, done_o = 0.

## Timing
- Request accepted at edge T0 (IDLE, req_i = 1). ready_o = 0 from T0 until DONE ends.
- WAIT occupies LATENCY cycles, XFER occupies WORDS cycles, DONE occupies 1 cycle.
- The first XFER cycle begins LATENCY cycles after T0. ready_o is back to 1 LATENCY+WORDS+1 cycles after T0.
- Back-to-back requests: req_i held high across DONE is accepted on the first IDLE cycle. Minimum request spacing is LATENCY+WORDS+2 cycles.
- Write beat k commits at the edge ending XFER cycle k. A fill that immediately follows a writeback to the same line returns the new data.
- All outputs are decoded from registered state and counters. read_data_o is combinational from the array and mem_addr_o.

## Test plan
- Reset, then idle: hold rst_i = 0 for 2 cycles → ready_o = 1, all other outputs 0; with req_i = 0 the outputs stay unchanged for 20 cycles.
- Fill with OFFSET_WIDTH = 4, LATENCY = 2, mem preloaded with word i = 0xA000_0000+i, addr_i = 0x0000_0048 → data_valid_o high on cycles T0+2..T0+5. mem_addr_o = 0x40, 0x44, 0x48, 0x4C with data 0xA000_0010..0xA000_0013. done_o pulses at T0+6; ready_o = 1 at T0+7.
- Writeback then fill: we_i = 1, addr_i = 0x80, write_data_i = 0xDEAD_0000+beat → the next fill of 0x80 returns 0xDEAD_0000..0xDEAD_0003.
- Reset mid-burst: rst_i = 0 during write beat 2 of line 0x100 → beats 0 and 1 written, beats 2 and 3 unchanged. Responder is IDLE with ready_o = 1 on the next cycle.
- Ignored request and aliasing: req_i pulsed during WAIT → no second burst. A fill of 0x1000 with MEM_DEPTH = 1024 returns the contents of line 0x0.
